// File: rtl/boot_loader.sv
// Byte-stream boot loader: sync, length, data words into RAM, checksum,
// then releases the core from reset once the image is verified.
module boot_loader #(
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst_n,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [15:0]       words_written
);

    typedef enum logic [2:0] {
        SYNC, LEN, DATA, CSUM, DONE, ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state;
    logic [1:0]        bcnt;
    logic [23:0]       sbuf;
    logic [31:0]       nwords;
    logic [31:0]       wcnt;
    logic [7:0]        sum;
    logic [ADDR_W-1:0] waddr;
    logic              fire;
    logic [31:0]       word;

    assign fire = rx_valid && rx_ready;
    // Shift buffer holds the first three bytes; the current byte completes the word.
    assign word = {rx_data, sbuf};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= SYNC;
            rx_ready      <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= BASE;
            mem_wdata     <= 32'd0;
            core_rst_n    <= 1'b0;
            done          <= 1'b0;
            err_code      <= 2'b00;
            words_written <= 16'd0;
            bcnt          <= 2'd0;
            sbuf          <= 24'd0;
            nwords        <= 32'd0;
            wcnt          <= 32'd0;
            sum           <= 8'd0;
            waddr         <= BASE;
        end else begin
            mem_we <= 1'b0;
            if (mem_we && words_written != 16'hFFFF)
                words_written <= words_written + 16'd1;
            if (state inside {SYNC, LEN, DATA, CSUM})
                rx_ready <= 1'b1;
            if (fire) begin
                unique case (state)
                    SYNC: begin
                        if (rx_data == 8'hA5)
                            state <= LEN;
                    end
                    LEN: begin
                        bcnt <= bcnt + 2'd1;
                        sbuf <= {rx_data, sbuf[23:8]};
                        if (bcnt == 2'd3) begin
                            nwords <= word;
                            if (word > 32'(MAX_WORDS)) begin
                                state    <= ERROR;
                                err_code <= 2'b01;
                                rx_ready <= 1'b0;
                            end else if (word == 32'd0) begin
                                state <= CSUM;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        bcnt <= bcnt + 2'd1;
                        sbuf <= {rx_data, sbuf[23:8]};
                        sum  <= sum + rx_data;
                        if (bcnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= word;
                            mem_addr  <= waddr;
                            waddr     <= waddr + ADDR_W'(4);
                            wcnt      <= wcnt + 32'd1;
                            if (wcnt + 32'd1 == nwords)
                                state <= CSUM;
                        end
                    end
                    CSUM: begin
                        rx_ready <= 1'b0;
                        if (rx_data == sum) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state    <= ERROR;
                            err_code <= 2'b10;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of the RAM byte address.
REQ-002 SHALL have parameter BASE_ADDR, default 0, byte address of the first word written.
REQ-003 SHALL have parameter MAX_WORDS, default 4096, largest accepted image length in words.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx_data  input  8  incoming image byte.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  block accepts byte; transfer when rx_valid && rx_ready.
REQ-009 SHALL have port mem_we  output  1  one-cycle RAM write strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  RAM byte address, word aligned.
REQ-011 SHALL have port mem_wdata  output  32  RAM write word.
REQ-012 SHALL have port core_rst_n  output  1  active-low reset to the riscv core.
REQ-013 SHALL have port done  output  1  image loaded and verified.
REQ-014 SHALL have port err_code  output  2  00 none, 01 length overflow, 10 checksum mismatch.
REQ-015 SHALL have port words_written  output  16  count of mem_we pulses since reset.

Function
REQ-016 SHALL implement states SYNC, LEN, DATA, CSUM, DONE, ERROR.
REQ-017 SHALL drive rx_ready=1 in SYNC, LEN, DATA, CSUM; 0 in DONE and ERROR.
REQ-018 SYNC: accepted byte 0xA5 -> LEN; any other byte consumed and discarded, stay SYNC.
REQ-019 LEN: SHALL accept 4 bytes, little-endian (first byte = bits 7:0), forming word count N.
REQ-020 After 4th LEN byte: N > MAX_WORDS -> ERROR, err_code=01; N == 0 -> CSUM; else -> DATA.
REQ-021 DATA: SHALL assemble each word from 4 bytes, first byte = bits 7:0, fourth = bits 31:24.
REQ-022 Cycle after the 4th byte of a word is accepted, SHALL pulse mem_we for exactly one cycle with mem_wdata = assembled word, mem_addr = BASE_ADDR + 4*k (k = word index from 0).
REQ-023 SHALL not stall rx during writes; a byte accepted in the mem_we cycle is valid.
REQ-024 mem_addr SHALL wrap modulo 2^ADDR_W; no error on wrap.
REQ-025 SHALL keep an 8-bit running sum (mod 256) of all DATA bytes; LEN and sync bytes excluded.
REQ-026 After N words written -> CSUM.
REQ-027 CSUM: one byte accepted; equals running sum -> DONE; else -> ERROR, err_code=10.
REQ-028 DONE: done=1, core_rst_n=1; both held until reset.
REQ-029 ERROR: core_rst_n=0, done=0, err_code held until reset.
REQ-030 core_rst_n SHALL be 0 in every state except DONE, and SHALL rise the cycle DONE is entered.
REQ-031 rx_valid with rx_ready=0 SHALL be ignored with no state change.
REQ-032 words_written SHALL increment on each mem_we, saturating at 0xFFFF.
REQ-033 mem_we SHALL be 0 in SYNC, LEN, CSUM, DONE, ERROR except the completing pulse of REQ-022.

Reset
REQ-034 rst_n low at a rising edge SHALL force: state SYNC, rx_ready=0 that cycle, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, core_rst_n=0, done=0, err_code=00, words_written=0, sum and byte counters 0.
REQ-035 Reset mid-word SHALL discard partial bytes; RAM contents already written are not altered.
REQ-036 rx_ready SHALL return to 1 the first cycle after rst_n is high.

Verification
REQ-037 Stream A5 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 | 82 -> mem_we at addr 0 data 0x00000013, addr 4 data 0x0000006F; done=1, core_rst_n=1, words_written=2.
REQ-038 Same stream, trailer 83 -> err_code=10, done=0, core_rst_n=0, rx_ready=0; 2 writes still occurred.
REQ-039 Stream 11 22 A5 00 00 00 00 00 -> junk discarded, zero writes, done=1.
REQ-040 MAX_WORDS=4, length 05 00 00 00 -> err_code=01 immediately after 4th LEN byte, no mem_we.
REQ-041 rst_n low after 2 of 4 bytes of word 1, then valid 1-word image -> single write at BASE_ADDR with new data, words_written=1.
REQ-042 Bytes offered back-to-back every cycle with random rx_valid gaps -> identical RAM contents and done timing independent of gap pattern, except shift by gap cycles.
